// File: rtl/abacus_pkg.sv
// Shared types and constants for the ABACUS snapshot streamer: FSM states,
// frame header layout and profiler window offsets.
package abacus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TS   = 2'd2,
    ST_READ = 2'd3
  } state_t;

  localparam logic [7:0]  SNAPSHOT_MAGIC = 8'hAB;
  localparam logic [15:0] WINDOW_INSTR   = 16'h0100;
  localparam logic [15:0] WINDOW_CACHE   = 16'h0200;

  localparam int unsigned HDR_MAGIC_W = 8;
  localparam int unsigned HDR_SEQ_W   = 8;
  localparam int unsigned HDR_RSVD_W  = 8;
  localparam int unsigned HDR_LEN_W   = 8;

  typedef struct packed {
    logic [HDR_MAGIC_W-1:0] magic;
    logic [HDR_SEQ_W-1:0]   seq;
    logic [HDR_RSVD_W-1:0]  rsvd;
    logic [HDR_LEN_W-1:0]   len;
  } hdr_t;

  function automatic logic [31:0] make_hdr(input logic [HDR_SEQ_W-1:0] seq,
                                           input logic [HDR_LEN_W-1:0] len);
    hdr_t h;
    h.magic = SNAPSHOT_MAGIC;
    h.seq   = seq;
    h.rsvd  = '0;
    h.len   = len;
    return h;
  endfunction

endpackage

// File: rtl/abacus_sync_fifo.sv
// Synchronous FIFO with a registered output stage (valid/ready) and a
// free-space count that includes the output register.
module abacus_sync_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      mcount;
  logic             load_out, mem_rd, mem_wr;

  // A write into an empty FIFO with a free output slot bypasses the array,
  // giving one cycle from write to rd_valid.
  always_comb begin
    load_out = !rd_valid || rd_ready;
    mem_rd   = load_out && (mcount != '0);
    mem_wr   = wr_en && !(load_out && (mcount == '0));
    free     = DEPTH_W - mcount - {{AW{1'b0}}, rd_valid};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mcount   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (mem_wr) wptr <= wptr + 1'b1;
      if (mem_rd) rptr <= rptr + 1'b1;
      mcount <= mcount + {{AW{1'b0}}, mem_wr} - {{AW{1'b0}}, mem_rd};
      if (load_out) begin
        if (mem_rd) begin
          rd_data  <= mem[rptr];
          rd_valid <= 1'b1;
        end else if (wr_en) begin
          rd_data  <= wr_data;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/abacus_snapshot_streamer.sv
// Periodic Wishbone burst reader of ABACUS profiler counters, framed into a
// valid/ready stream. Optional timestamp word: ABACUS_SNAPSHOT_TIMESTAMP_EN.
module abacus_snapshot_streamer
  import abacus_pkg::*;
#(
  parameter logic [31:0] ABACUS_BASE_ADDR = 32'hf0030000,
  parameter logic [15:0] WINDOW_OFFSET    = WINDOW_INSTR,
  parameter int unsigned NUM_WORDS        = 11,
  parameter int unsigned FIFO_DEPTH       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_enable,
  input  logic [31:0] cfg_interval,
  output logic        m_wb_cyc,
  output logic        m_wb_stb,
  output logic        m_wb_we,
  output logic [31:0] m_wb_adr,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack,
  output logic [31:0] sample_data,
  output logic        sample_valid,
  output logic        sample_last,
  input  logic        sample_ready,
  output logic [15:0] dropped_frames,
  output logic        busy
);

  logic [31:0] ts_q;
  logic        accept;

`ifdef ABACUS_SNAPSHOT_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (accept) ts_q <= ts_cnt;
    end
  end
`else
  localparam bit TS_EN = 1'b0;
  assign ts_q = '0;
`endif

  localparam int unsigned FRAME_LEN   = NUM_WORDS + 1 + (TS_EN ? 1 : 0);
  localparam int unsigned FW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] FRAME_LEN_W = FW'(FRAME_LEN);
  localparam logic [7:0]  HDR_LEN     = 8'(FRAME_LEN - 1);
  localparam logic [7:0]  LAST_IDX    = 8'(NUM_WORDS - 1);
  localparam logic [31:0] WINDOW_ADDR = ABACUS_BASE_ADDR + {16'h0000, WINDOW_OFFSET};

  state_t          state;
  logic [7:0]      seq;
  logic [7:0]      widx;
  logic            en_q, tick, start_burst;
  logic [31:0]     tmr;
  logic [FW-1:0]   fifo_free;
  logic            fifo_wr;
  logic [32:0]     fifo_wdata;
  logic [32:0]     fifo_rdata;

  assign m_wb_we = 1'b0;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    tick        = cfg_enable && en_q && (cfg_interval != '0) && (tmr == '0);
    accept      = tick && (state == ST_IDLE) && (fifo_free >= FRAME_LEN_W);
    start_burst = (state == ST_TS) || ((state == ST_HDR) && !TS_EN);
  end

  // Timer reload on enable rise or expiry; holds while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= 1'b0;
      tmr  <= '0;
    end else begin
      en_q <= cfg_enable;
      if ((cfg_enable && !en_q) || tick)
        tmr <= cfg_interval - 32'd1;
      else if (cfg_enable && (tmr != '0))
        tmr <= tmr - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dropped_frames <= '0;
    else if (tick && !accept && (dropped_frames != '1))
      dropped_frames <= dropped_frames + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      seq      <= '0;
      widx     <= '0;
      m_wb_cyc <= 1'b0;
      m_wb_stb <= 1'b0;
      m_wb_adr <= '0;
    end else begin
      if (start_burst) begin
        m_wb_cyc <= 1'b1;
        m_wb_stb <= 1'b1;
        m_wb_adr <= WINDOW_ADDR;
        widx     <= '0;
      end
      case (state)
        ST_IDLE: if (accept) state <= ST_HDR;
        ST_HDR: begin
          seq   <= seq + 8'd1;
          state <= TS_EN ? ST_TS : ST_READ;
        end
        ST_TS:   state <= ST_READ;
        ST_READ: begin
          if (m_wb_ack) begin
            if (widx == LAST_IDX) begin
              state    <= ST_IDLE;
              m_wb_cyc <= 1'b0;
              m_wb_stb <= 1'b0;
            end else begin
              widx     <= widx + 8'd1;
              m_wb_adr <= m_wb_adr + 32'd4;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    case (state)
      ST_HDR: begin
        fifo_wr    = 1'b1;
        fifo_wdata = {1'b0, make_hdr(seq, HDR_LEN)};
      end
      ST_TS: begin
        fifo_wr    = 1'b1;
        fifo_wdata = {1'b0, ts_q};
      end
      ST_READ: begin
        if (m_wb_ack) begin
          fifo_wr    = 1'b1;
          fifo_wdata = {(widx == LAST_IDX), m_wb_dat_i};
        end
      end
      default: ;
    endcase
  end

  abacus_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wdata),
    .rd_data  (fifo_rdata),
    .rd_valid (sample_valid),
    .rd_ready (sample_ready),
    .free     (fifo_free)
  );

  assign sample_data = fifo_rdata[31:0];
  assign sample_last = fifo_rdata[32];

endmodule
